sample_sum_accumulator: RTL and testbench

- Upstream stage of the arithmetic datapath.
- Collects a group of 2^N_LOG2 unsigned samples over a valid/ready input stream and presents their exact sum on a valid/ready output.
- The downstream shift-right divider (for N_LOG2=2, a >>2 stage) turns that sum into a mean.
- Accumulation is sequential: one sample accepted per clock, with back-pressure while a finished sum waits to be taken.

---
 rtl/sample_sum_accumulator.sv | 110 +++++++++++
 tb/tb_sample_sum_accumulator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sample_sum_accumulator.sv
// sample_sum_accumulator
//   Accepts one unsigned sample per clock over a valid/ready stream, sums
//   groups of N = 2**N_LOG2 samples and holds each finished sum on a
//   valid/ready output until downstream takes it. While a sum is held,
//   input acceptance follows out_ready, so a new group can start on the
//   same cycle the old sum leaves.
//
//   Parameters: DW     sample width
//               N_LOG2 log2 of samples per group (1..4)
//   Ports:      clk, rst (sync, active high), clr (drop partial group)
//               in_valid/in_ready/in_data      sample stream
//               out_valid/out_ready/out_sum    group sum (DW+N_LOG2 bits)
//               out_avg (SAMPLE_SUM_AVG_OUT_EN only) truncating mean
//   Optional:   define SAMPLE_SUM_AVG_OUT_EN to add the registered out_avg.
module sample_sum_accumulator #(
  parameter int DW     = 4,
  parameter int N_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW+N_LOG2-1:0] out_sum
`ifdef SAMPLE_SUM_AVG_OUT_EN
  ,
  output logic [DW-1:0]        out_avg
`endif
);
  localparam int SW = DW + N_LOG2;
  localparam logic [N_LOG2-1:0] CNT_LAST = '1;

  typedef enum logic {ACC, HOLD} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     acc, acc_nxt, acc_plus;
  logic [N_LOG2-1:0] cnt, cnt_nxt;
  logic              sum_ld;
  logic              accept, xfer;

  // in_ready only sees state and out_ready; no in_valid/in_data path out.
  assign in_ready  = (state == ACC) | out_ready;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign acc_plus  = acc + SW'(in_data);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    sum_ld    = 1'b0;
    case (state)
      ACC: begin
        if (clr) begin
          // a sample arriving with clr is part of the discarded group
          acc_nxt = '0;
          cnt_nxt = '0;
        end else if (accept) begin
          if (cnt == CNT_LAST) begin
            sum_ld    = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            acc_nxt = acc_plus;
            cnt_nxt = cnt + N_LOG2'(1);
          end
        end
      end
      HOLD: begin
        // clr is ignored here so a finished sum is never lost
        if (xfer) begin
          state_nxt = ACC;
          if (accept) begin
            // acc is already zero; this sample opens the next group
            acc_nxt = SW'(in_data);
            cnt_nxt = N_LOG2'(1);
          end
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACC;
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      if (sum_ld) out_sum <= acc_plus;
    end
  end

`ifdef SAMPLE_SUM_AVG_OUT_EN
  always_ff @(posedge clk) begin
    if (rst)         out_avg <= '0;
    else if (sum_ld) out_avg <= DW'(acc_plus >> N_LOG2);
  end
`endif

endmodule

// File: tb/tb_sample_sum_accumulator.sv
module tb_sample_sum_accumulator;
  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  logic clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] in_data = '0;

  logic       rdy0, rdy1, vld0, vld1;
  logic [5:0] s0;
  logic [6:0] s1;
`ifdef SAMPLE_SUM_AVG_OUT_EN
  logic [3:0] avg0, avg1;
`endif

  always #5 clk = ~clk;

  sample_sum_accumulator #(.DW(4), .N_LOG2(2)) dut0 (
    .clk(clk), .rst(rst0), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .out_valid(vld0), .out_ready(out_ready), .out_sum(s0)
`ifdef SAMPLE_SUM_AVG_OUT_EN
    , .out_avg(avg0)
`endif
  );

  sample_sum_accumulator #(.DW(4), .N_LOG2(3)) dut1 (
    .clk(clk), .rst(rst1), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .out_valid(vld1), .out_ready(out_ready), .out_sum(s1)
`ifdef SAMPLE_SUM_AVG_OUT_EN
    , .out_avg(avg1)
`endif
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: list of samples in the open group, a pending-sum flag,
  // and the last completed sum (0 after reset).
  int          nn[2] = '{4, 8};
  int          lg[2] = '{2, 3};
  int unsigned gv[2][16];
  int          gc[2];
  bit          pend[2];
  int unsigned esum[2];
  bit          seen[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit r;
      int unsigned s;
      r = (k == 0) ? rst0 : rst1;
      if (r) begin
        gc[k] = 0; pend[k] = 1'b0; esum[k] = 0; seen[k] = 1'b1;
      end else if (pend[k]) begin
        if (out_ready) begin
          pend[k] = 1'b0;
          if (in_valid) begin gv[k][0] = in_data; gc[k] = 1; end
        end
      end else if (clr) begin
        gc[k] = 0;
      end else if (in_valid) begin
        gv[k][gc[k]] = in_data;
        gc[k]++;
        if (gc[k] == nn[k]) begin
          s = 0;
          for (int j = 0; j < nn[k]; j++) s += gv[k][j];
          esum[k] = s; pend[k] = 1'b1; gc[k] = 0;
        end
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (seen[0]) begin
      chk("rdy0", int'(rdy0), int'(!pend[0] || out_ready));
      chk("vld0", int'(vld0), int'(pend[0]));
      chk("sum0", int'(s0), int'(esum[0]));
`ifdef SAMPLE_SUM_AVG_OUT_EN
      chk("avg0", int'(avg0), int'(esum[0] >> lg[0]));
`endif
    end
    if (seen[1]) begin
      chk("rdy1", int'(rdy1), int'(!pend[1] || out_ready));
      chk("vld1", int'(vld1), int'(pend[1]));
      chk("sum1", int'(s1), int'(esum[1]));
`ifdef SAMPLE_SUM_AVG_OUT_EN
      chk("avg1", int'(avg1), int'(esum[1] >> lg[1]));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit v, input int d, input bit c, input bit o);
    in_valid = v; in_data = 4'(d); clr = c; out_ready = o;
    @(posedge clk); #1;
  endtask

  initial begin
    int n0, n1;
    repeat (2) step(0, 0, 0, 0);
    rst0 = 1'b0;

    // 3,5,7,9 -> 24
    step(1, 3, 0, 1); step(1, 5, 0, 1); step(1, 7, 0, 1);
    chk("d1_pre_vld", int'(vld0), 0);
    step(1, 9, 0, 1);
    chk("d1_vld", int'(vld0), 1);
    chk("d1_sum", int'(s0), 24);
`ifdef SAMPLE_SUM_AVG_OUT_EN
    chk("d1_avg", int'(avg0), 6);
`endif
    step(0, 0, 0, 1);
    chk("d1_drop", int'(vld0), 0);

    // 15 x4 -> 60, no wrap
    repeat (4) step(1, 15, 0, 1);
    chk("d2_sum", int'(s0), 60);
`ifdef SAMPLE_SUM_AVG_OUT_EN
    chk("d2_avg", int'(avg0), 15);
`endif
    step(0, 0, 0, 1);

    // stall: sum held, in_ready low; release with a same-cycle accept
    step(1, 1, 0, 1); step(1, 2, 0, 1); step(1, 3, 0, 1); step(1, 4, 0, 0);
    chk("d3_sum", int'(s0), 10);
    repeat (3) begin
      step(1, 9, 0, 0);
      chk("d3_hold", int'(s0), 10);
      chk("d3_rdy", int'(rdy0), 0);
      chk("d3_vld", int'(vld0), 1);
    end
    step(1, 2, 0, 1);
    chk("d3_xfer", int'(vld0), 0);
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    chk("d3_next_vld", int'(vld0), 1);
    chk("d3_next_sum", int'(s0), 5);
    step(0, 0, 0, 1);

    // clr discards partial group and the sample with it
    step(1, 4, 0, 1); step(1, 4, 0, 1); step(1, 4, 1, 1);
    step(1, 1, 0, 1); step(1, 2, 0, 1); step(1, 3, 0, 1);
    chk("d4_pre_vld", int'(vld0), 0);
    step(1, 4, 0, 1);
    chk("d4_sum", int'(s0), 10);
    step(0, 0, 0, 1);

    // reset in HOLD, then reset beats clr + in_valid
    step(1, 3, 0, 0); step(1, 5, 0, 0); step(1, 7, 0, 0); step(1, 9, 0, 0);
    chk("d5_sum", int'(s0), 24);
    rst0 = 1'b1;
    step(0, 0, 0, 0);
    chk("d5_rst_vld", int'(vld0), 0);
    chk("d5_rst_sum", int'(s0), 0);
    chk("d5_rst_rdy", int'(rdy0), 1);
    step(1, 7, 1, 1);
    rst0 = 1'b0;
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    chk("d5_no_acc", int'(vld0), 0);
    step(1, 1, 0, 1);
    chk("d5_sum4", int'(s0), 4);
    step(0, 0, 0, 1);

    // N=8 instance: 8 x 15 -> 120, then sustained throughput
    rst1 = 1'b0;
    repeat (8) step(1, 15, 0, 1);
    chk("d6_vld", int'(vld1), 1);
    chk("d6_sum", int'(s1), 120);
    n0 = 0; n1 = 0;
    repeat (32) begin
      step(1, int'($urandom_range(0, 15)), 0, 1);
      n0 += int'(vld0); n1 += int'(vld1);
    end
    chk("d6_rate8", n1, 4);
    chk("d6_rate4", n0, 8);

    // randomized traffic, checked by the model every cycle
    repeat (3000) begin
      rst0 = ($urandom_range(0, 199) == 0);
      rst1 = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end
    rst0 = 1'b0; rst1 = 1'b0;
    step(0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
